// File: rtl/dff_wr_arbiter.sv
// Round-robin write arbiter feeding a shared enabled DFF register; one grant per two cycles.
// Optional macro DFF_ARB_PRIO_EN gives requester 0 absolute priority over the round-robin.
module dff_wr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic                   reg_en,
  output logic [WIDTH-1:0]       reg_d,
  output logic                   busy,
  output logic [7:0]             wr_count
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] winner;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // First asserted request at or after last+1, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(last) + off) % N_REQ;
      if (!found && r[IDX_W'(idx)]) begin
        found = 1'b1;
        pick  = IDX_W'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
`ifdef DFF_ARB_PRIO_EN
    if (req[0]) winner = '0;
    else        winner = rr_pick(req, last_winner);
`else
    winner = rr_pick(req, last_winner);
`endif
  end

  // Outputs are registered; a grant occupies exactly the cycle after the IDLE->GRANT edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt         <= '0;
      reg_en      <= 1'b0;
      reg_d       <= '0;
      busy        <= 1'b0;
      wr_count    <= '0;
      last_winner <= IDX_W'(N_REQ - 1);
    end else if (state == GRANT) begin
      state    <= IDLE;
      gnt      <= '0;
      reg_en   <= 1'b0;
      busy     <= 1'b0;
      wr_count <= sat_inc(wr_count);
    end else if (|req) begin
      state       <= GRANT;
      gnt         <= ONE_HOT0 << winner;
      reg_en      <= 1'b1;
      reg_d       <= wdata[int'(winner)*WIDTH +: WIDTH];
      busy        <= 1'b1;
      last_winner <= winner;
    end
  end

endmodule

// File: tb/tb_dff_wr_arbiter.sv
// Bench for dff_wr_arbiter: directed literal scenarios plus randomized traffic against a behavioural model.
module tb_dff_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic           reg_en;
  logic [W-1:0]   reg_d;
  logic           busy;
  logic [7:0]     wr_count;

  dff_wr_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .reg_en(reg_en), .reg_d(reg_d), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: a write is either in flight (grant cycle) or not.
  bit           m_in_grant = 1'b0;
  logic [N-1:0] m_gnt = '0;
  logic         m_en = 1'b0;
  logic [W-1:0] m_d = '0;
  logic         m_busy = 1'b0;
  int           m_cnt = 0;
  int           m_last = N - 1;

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_in_grant <= 1'b0; m_gnt <= '0; m_en <= 1'b0; m_d <= '0;
      m_busy <= 1'b0; m_cnt <= 0; m_last <= N - 1;
    end else if (m_in_grant) begin
      m_in_grant <= 1'b0; m_gnt <= '0; m_en <= 1'b0; m_busy <= 1'b0;
      m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
    end else if (req != '0) begin
      w = -1;
`ifdef DFF_ARB_PRIO_EN
      if (req[0]) w = 0;
`endif
      for (int k = 0; k < N; k++)
        if (w < 0 && req[(m_last + 1 + k) % N]) w = (m_last + 1 + k) % N;
      m_in_grant <= 1'b1;
      m_gnt  <= N'(1 << w);
      m_en   <= 1'b1;
      m_d    <= wdata[w*W +: W];
      m_busy <= 1'b1;
      m_last <= w;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("reg_en", 32'(reg_en), 32'(m_en));
      check("reg_d", 32'(reg_d), 32'(m_d));
      check("busy", 32'(busy), 32'(m_busy));
      check("wr_count", 32'(wr_count), m_cnt);
    end
  end

  initial begin
    logic [31:0] r;
    logic [31:0] nb;
    rst = 1'b1; req = '1; wdata = '0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_en", 32'(reg_en), 32'h0);
    check("rst_d", 32'(reg_d), 32'h0);
    check("rst_cnt", 32'(wr_count), 32'h0);

    // Single write from requester 2; wdata changes during the grant must not leak.
    rst = 1'b0; req = 4'b0100; wdata = 32'h00A5_0000;
    @(negedge clk);
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_en", 32'(reg_en), 32'h1);
    check("single_d", 32'(reg_d), 32'hA5);
    check("single_busy", 32'(busy), 32'h1);
    req = '0; wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("single_hold_d", 32'(reg_d), 32'hA5);
    check("single_idle_en", 32'(reg_en), 32'h0);
    check("single_cnt", 32'(wr_count), 32'h1);

    // Fairness from reset: all four requesting, each dropped on its grant.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'hF; wdata = 32'h4433_2211;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check("fair_gnt", 32'(gnt), 32'(1 << i));
      check("fair_d", 32'(reg_d), 32'(8'h11 * (i + 1)));
      req = req & ~N'(1 << i);
      @(negedge clk);
      check("fair_gap", 32'(gnt), 32'h0);
    end
    check("fair_cnt", 32'(wr_count), 32'h4);

    // Wrap: last winner is 3.
    req = 4'b1001;
    @(negedge clk);
    check("wrap_gnt0", 32'(gnt), 32'h1);
    req = 4'b1000;
    @(negedge clk);
    @(negedge clk);
    check("wrap_gnt3", 32'(gnt), 32'h8);
    req = '0;
    @(negedge clk);

    // Reset during the grant cycle aborts the write.
    req = 4'b0010;
    @(negedge clk);
    check("mid_gnt", 32'(gnt), 32'h2);
    rst = 1'b1; req = '0;
    @(negedge clk);
    check("mid_en", 32'(reg_en), 32'h0);
    check("mid_cnt", 32'(wr_count), 32'h0);
    check("mid_busy", 32'(busy), 32'h0);

    // Requests during reset are ignored; lowest index wins after release.
    req = 4'b0110;
    @(negedge clk);
    check("inrst_gnt", 32'(gnt), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", 32'(gnt), 32'h2);
    req = 4'b0100;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_gnt2", 32'(gnt), 32'h4);
    req = '0;
    @(negedge clk);

    // Requester 0 held high alongside requester 1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
`ifdef DFF_ARB_PRIO_EN
      check("prio_gnt", 32'(gnt), 32'h1);
`else
      check("prio_gnt", 32'(gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
`endif
      @(negedge clk);
    end
    req = '0;

    // Saturation of the write counter.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (260) begin
      req = 4'b0001;
      @(negedge clk);
      req = '0;
      @(negedge clk);
    end
    check("sat_cnt", 32'(wr_count), 32'd255);

    // Randomized traffic: requests held until granted, occasional resets.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2000) begin
      r  = $urandom;
      nb = $urandom & ~32'(m_gnt);
      rst = (r[6:0] == 7'd0);
      if ($urandom_range(0, 2) == 0) req = (req & ~m_gnt) | nb[N-1:0];
      else                           req = req & ~m_gnt;
      wdata = $urandom;
      @(negedge clk);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
